// File: rtl/cache_types.sv
// cache_types: shared types and defaults for the victim write-back buffer.
package cache_types;
  localparam int WBUF_DEPTH = 4;
  typedef struct packed {
    logic         valid;
    logic [11:0]  pmem_address_base;
    logic [127:0] cache_line;
  } wbuf_entry_t;
  typedef enum logic [1:0] {IDLE, RESP, FETCH, DRAIN} wbuf_state_t;
endpackage

// File: rtl/victim_wb_buffer_if.sv
// victim_wb_buffer_if: upstream victim-cache port and downstream L2 port of the write-back buffer.
interface victim_wb_buffer_if;
  logic [15:0]  up_address;
  logic [127:0] up_wdata;
  logic         up_read;
  logic         up_write;
  logic [127:0] up_rdata;
  logic         up_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         wbuf_empty;
  modport master (
    output up_address, up_wdata, up_read, up_write, pmem_rdata, pmem_resp,
    input  up_rdata, up_resp, pmem_address, pmem_wdata, pmem_read, pmem_write, wbuf_empty
  );
  modport slave (
    input  up_address, up_wdata, up_read, up_write, pmem_rdata, pmem_resp,
    output up_rdata, up_resp, pmem_address, pmem_wdata, pmem_read, pmem_write, wbuf_empty
  );
endinterface

// File: rtl/wbuf_match.sv
// wbuf_match: compares an incoming line base against every buffered entry; the youngest hit wins.
module wbuf_match
  import cache_types::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic [DEPTH-1:0]         i_valid,
  input  logic [11:0]              i_bases [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_tail,
  input  logic [11:0]              i_base,
  output logic                     o_hit,
  output logic [$clog2(DEPTH)-1:0] o_idx
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] w_j;
  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_j = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_j = i_tail - AW'(k);
      if (i_valid[w_j] && i_bases[w_j] == i_base) begin
        o_hit = 1'b1;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/victim_wb_buffer.sv
// victim_wb_buffer: write-back buffer between a victim cache and L2; absorbs evictions, serves hits, drains when idle.
module victim_wb_buffer
  import cache_types::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input logic               clk,
  input logic               reset,
  victim_wb_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  wbuf_state_t r_state, w_next;
  wbuf_entry_t r_ent [DEPTH];
  logic [AW-1:0] r_head, r_tail, w_idx;
  logic [AW:0] r_count;
  logic [127:0] r_rdata;
  logic [DEPTH-1:0] w_valid;
  logic [11:0] w_bases [DEPTH];
  logic [11:0] w_base;
  logic w_hit, w_full, w_empty, w_push, w_merge, w_rd_hit, w_fill, w_pop, w_unused;
  assign w_base = bus.up_address[15:4];
  assign w_unused = ^bus.up_address[3:0];
  assign w_full = r_count == (AW+1)'(DEPTH);
  assign w_empty = r_count == '0;
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    assign w_valid[e] = r_ent[e].valid;
    assign w_bases[e] = r_ent[e].pmem_address_base;
  end
  wbuf_match #(.DEPTH(DEPTH)) u_match (
    .i_valid(w_valid),
    .i_bases(w_bases),
    .i_tail (r_tail),
    .i_base (w_base),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );
  // Upstream requests outrank draining; a write to a full buffer forces one drain first.
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_merge = 1'b0;
    w_rd_hit = 1'b0;
    w_fill = 1'b0;
    w_pop = 1'b0;
    case (r_state)
      IDLE:
        if (bus.up_write) begin
          w_merge = w_hit;
          w_push = !w_hit && !w_full;
          w_next = (w_hit || !w_full) ? RESP : DRAIN;
        end else if (bus.up_read) begin
          w_rd_hit = w_hit;
          w_next = w_hit ? RESP : FETCH;
        end else if (!w_empty) begin
          w_next = DRAIN;
        end
      RESP: w_next = IDLE;
      FETCH:
        if (bus.pmem_resp) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      DRAIN:
        if (bus.pmem_resp) begin
          w_pop = 1'b1;
          w_next = IDLE;
        end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_rdata <= '0;
      r_ent <= '{default: '0};
    end else begin
      r_state <= w_next;
      r_head <= r_head + AW'(w_pop);
      r_tail <= r_tail + AW'(w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_ent[r_tail] <= '{valid: 1'b1, pmem_address_base: w_base, cache_line: bus.up_wdata};
      if (w_merge) r_ent[w_idx].cache_line <= bus.up_wdata;
      if (w_pop) r_ent[r_head].valid <= 1'b0;
      if (w_rd_hit) r_rdata <= r_ent[w_idx].cache_line;
      if (w_fill) r_rdata <= bus.pmem_rdata;
    end
  end
  assign bus.up_resp = (r_state == RESP) || (r_state == FETCH && bus.pmem_resp);
  assign bus.up_rdata = (r_state == FETCH) ? bus.pmem_rdata : r_rdata;
  assign bus.pmem_read = r_state == FETCH;
  assign bus.pmem_write = r_state == DRAIN;
  assign bus.pmem_address = {(r_state == DRAIN) ? r_ent[r_head].pmem_address_base : w_base, 4'h0};
  assign bus.pmem_wdata = r_ent[r_head].cache_line;
  assign bus.wbuf_empty = w_empty;
endmodule

// File: tb/tb_victim_wb_buffer.sv
// tb_victim_wb_buffer: directed checks of the victim write-back buffer with a hand-driven L2.
module tb_victim_wb_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  localparam logic [127:0] DA = {4{32'hAAAA_0001}};
  localparam logic [127:0] DB = {4{32'hBBBB_0002}};
  localparam logic [127:0] DC = {4{32'hCCCC_0003}};
  localparam logic [127:0] DD = {4{32'hDDDD_0004}};
  localparam logic [127:0] DF = {4{32'hFFFF_0006}};
  localparam logic [127:0] DG = {4{32'h6666_0007}};
  localparam logic [127:0] DR = {4{32'h1234_5678}};
  victim_wb_buffer_if bus();
  victim_wb_buffer #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [127:0] dat(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic w, input logic r, input logic [15:0] a, input logic [127:0] d);
    bus.up_write = w;
    bus.up_read = r;
    bus.up_address = a;
    bus.up_wdata = d;
  endtask
  task automatic wait_resp(input string tag, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.up_resp && n < lim);
    chk(tag, 128'(bus.up_resp), 128'(1));
  endtask
  task automatic drain_expect(input string tag, input logic [15:0] a, input logic [127:0] d);
    int n = 0;
    while (!bus.pmem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr"}, 128'(bus.pmem_write), 128'(1));
    chk({tag, "_addr"}, 128'(bus.pmem_address), 128'(a));
    chk({tag, "_data"}, bus.pmem_wdata, d);
    chk({tag, "_rd"}, 128'(bus.pmem_read), 128'(0));
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
  endtask
  initial begin
    req(1'b0, 1'b0, 16'h0, '0);
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_empty", 128'(bus.wbuf_empty), 128'(1));
    chk("rst_resp", 128'(bus.up_resp), 128'(0));
    chk("rst_pmem", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
    chk("rst_rdata", bus.up_rdata, '0);
    reset = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 16'h1230, DA);
    @(negedge clk);
    chk("wr_resp", 128'(bus.up_resp), 128'(1));
    req(1'b0, 1'b0, 16'h1230, DA);
    @(negedge clk);
    chk("wr_idle_nowr", 128'(bus.pmem_write), 128'(0));
    chk("wr_not_empty", 128'(bus.wbuf_empty), 128'(0));
    @(negedge clk);
    drain_expect("drain1", 16'h1230, DA);
    chk("drain1_empty", 128'(bus.wbuf_empty), 128'(1));
    req(1'b1, 1'b0, 16'h0400, DB);
    @(negedge clk);
    chk("hit_wr_resp", 128'(bus.up_resp), 128'(1));
    req(1'b0, 1'b1, 16'h0400, '0);
    @(negedge clk);
    chk("hit_rd_wait", 128'(bus.up_resp), 128'(0));
    chk("hit_no_fetch", 128'(bus.pmem_read), 128'(0));
    @(negedge clk);
    chk("hit_rd_resp", 128'(bus.up_resp), 128'(1));
    chk("hit_rd_data", bus.up_rdata, DB);
    chk("hit_no_fetch2", 128'(bus.pmem_read), 128'(0));
    req(1'b0, 1'b0, 16'h0400, '0);
    drain_expect("drain2", 16'h0400, DB);
    chk("drain2_empty", 128'(bus.wbuf_empty), 128'(1));
    req(1'b1, 1'b0, 16'h0500, DC);
    @(negedge clk);
    chk("merge_resp1", 128'(bus.up_resp), 128'(1));
    req(1'b1, 1'b0, 16'h0500, DD);
    @(negedge clk);
    chk("merge_wait", 128'(bus.up_resp), 128'(0));
    @(negedge clk);
    chk("merge_resp2", 128'(bus.up_resp), 128'(1));
    req(1'b0, 1'b0, 16'h0500, '0);
    drain_expect("drain3", 16'h0500, DD);
    chk("merge_single", 128'(bus.wbuf_empty), 128'(1));
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 16'h1000 + 16'(i * 16), dat(i));
      wait_resp($sformatf("fill%0d", i), 4);
    end
    req(1'b1, 1'b0, 16'h1040, dat(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("full_stall%0d", i), 128'(bus.up_resp), 128'(0));
    end
    chk("full_drain_wr", 128'(bus.pmem_write), 128'(1));
    chk("full_drain_addr", 128'(bus.pmem_address), 128'(16'h1000));
    chk("full_drain_data", bus.pmem_wdata, dat(0));
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    chk("full_after_pop", 128'(bus.up_resp), 128'(0));
    @(negedge clk);
    chk("full_accept", 128'(bus.up_resp), 128'(1));
    req(1'b0, 1'b0, 16'h0, '0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("full_nonempty%0d", i), 128'(bus.wbuf_empty), 128'(0));
      drain_expect($sformatf("fdrain%0d", i), 16'h1000 + 16'(i * 16), dat(i));
    end
    chk("full_all_drained", 128'(bus.wbuf_empty), 128'(1));
    req(1'b1, 1'b1, 16'h3330, DF);
    @(negedge clk);
    chk("both_wr_wins", 128'(bus.up_resp), 128'(1));
    chk("both_no_fetch", 128'(bus.pmem_read), 128'(0));
    req(1'b0, 1'b0, 16'h0, '0);
    drain_expect("drain_both", 16'h3330, DF);
    req(1'b0, 1'b1, 16'h7F35, '0);
    @(negedge clk);
    chk("fetch_rd", 128'(bus.pmem_read), 128'(1));
    chk("fetch_addr", 128'(bus.pmem_address), 128'(16'h7F30));
    chk("fetch_no_wr", 128'(bus.pmem_write), 128'(0));
    chk("fetch_no_resp", 128'(bus.up_resp), 128'(0));
    @(negedge clk);
    chk("fetch_stall", 128'(bus.up_resp), 128'(0));
    bus.pmem_rdata = DR;
    bus.pmem_resp = 1'b1;
    #1;
    chk("fetch_resp", 128'(bus.up_resp), 128'(1));
    chk("fetch_data", bus.up_rdata, DR);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    req(1'b0, 1'b0, 16'h0, '0);
    chk("fetch_hold", bus.up_rdata, DR);
    chk("fetch_done_rd", 128'(bus.pmem_read), 128'(0));
    req(1'b1, 1'b0, 16'h2220, DG);
    @(negedge clk);
    chk("rst_wr_resp", 128'(bus.up_resp), 128'(1));
    req(1'b0, 1'b0, 16'h0, '0);
    repeat (2) @(negedge clk);
    chk("rst_drain_active", 128'(bus.pmem_write), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_drop_wr", 128'(bus.pmem_write), 128'(0));
    chk("async_empty", 128'(bus.wbuf_empty), 128'(1));
    chk("async_rdata", bus.up_rdata, '0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", i), 128'({bus.pmem_read, bus.pmem_write, bus.wbuf_empty}), 128'(3'b001));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
